// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared types and constants for the PS/2 host transmitter.
//   Latency: n/a (types, constants and elaboration-time helpers only).
//   Backpressure: n/a.
// Contents: FSM state enum, frame/edge constants, microsecond-to-cycle helpers.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAITIDLE
  } state_e;

  typedef logic [7:0] byte_t;

  localparam int FRAME_BITS = 11;  // start, 8 data, parity, stop
  localparam int INH_W      = 13;  // inhibit counter width
  localparam int TO_W       = 20;  // frame timeout counter width
  localparam int EDGE_W     = 4;   // falling-edge counter width

  // Edge count held just before the 10th clock fall (the stop bit);
  // the fall after that one is the device ACK.
  localparam logic [EDGE_W-1:0] STOP_EDGE_IDX = 4'd9;

  // 64-bit math: CLK_HZ * TIMEOUT_US overflows 32 bits at default settings.
  function automatic int us_to_cycles(input longint clk_hz, input longint us);
    return int'((clk_hz * us) / longint'(1_000_000));
  endfunction

  function automatic int inhibit_cyc(input int clk_hz, input int us);
    return us_to_cycles(longint'(clk_hz), longint'(us));
  endfunction

  function automatic int timeout_cyc(input int clk_hz, input int us);
    return us_to_cycles(longint'(clk_hz), longint'(us));
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: CPU-side load/status bundle of the PS/2 host transmitter.
//   Latency: n/a (wires only).
//   Backpressure: none; a load strobe is dropped while busy is high.
// Signals: wr_stb/wr_data (master -> slave), busy/done/err (slave -> master).
interface ps2_host_tx_if;
  import ps2_host_tx_pkg::*;

  logic  wr_stb;   // one-cycle load strobe
  byte_t wr_data;  // byte to send, captured on wr_stb
  logic  busy;     // frame in progress
  logic  done;     // sticky: last frame ACKed
  logic  err;      // sticky: last frame NAKed or timed out

  modport master (output wr_stb, output wr_data, input busy, input done, input err);
  modport slave  (input wr_stb, input wr_data, output busy, output done, output err);
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// ps2_host_tx_line_sync: 2-FF synchroniser for one open-drain PS/2 line, optional glitch filter.
//   Latency: 2 cycles raw; FILTER_LEN more cycles when FILTER_EN is set.
//   Backpressure: none.
// Ports: CLK50MHz, nRESET (sync, active-low), line_i (async raw line), lvl_o (synced level).
module ps2_host_tx_line_sync #(
  parameter bit FILTER_EN  = 1'b0,
  parameter int FILTER_LEN = 4
) (
  input  logic CLK50MHz,
  input  logic nRESET,
  input  logic line_i,
  output logic lvl_o
);

  logic s1_q, s2_q;

  // Reset to 1: an idle open-drain bus reads high, so no false edge after reset.
  always_ff @(posedge CLK50MHz) begin
    if (!nRESET) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= line_i;
      s2_q <= s1_q;
    end
  end

  if (FILTER_EN) begin : g_filt
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic          lvl_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts consecutive samples that differ from the accepted level.
    always_ff @(posedge CLK50MHz) begin
      if (!nRESET) begin
        lvl_q <= 1'b1;
        cnt_q <= '0;
      end else if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        lvl_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign lvl_o = lvl_q;
  end else begin : g_raw
    assign lvl_o = s2_q;
  end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 frame transmitter (start, 8 data LSB first, odd parity, stop, ACK).
//   Latency: wr_stb -> ps2_clk_oe high in 2 cycles; then INHIBIT_US of clock inhibit before the device clocks.
//   Backpressure: wr_stb dropped while busy; frame aborted with err after TIMEOUT_US without completion.
// Ports: CLK50MHz, nRESET (sync, active-low); host (load/status bundle, slave side);
//        ps2_clk_in/ps2_data_in (raw lines); ps2_clk_oe/ps2_data_oe (1 = pull low); rx_inhibit.
// Build option: define PS2_TX_CLK_FILTER_EN to glitch-filter the synced PS/2 clock over FILTER_LEN samples.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000,
  parameter int FILTER_LEN = 4
) (
  input  logic         CLK50MHz,
  input  logic         nRESET,
  ps2_host_tx_if.slave host,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  output logic         rx_inhibit
);

  localparam int INH_CYC = inhibit_cyc(CLK_HZ, INHIBIT_US);
  localparam int TO_CYC  = timeout_cyc(CLK_HZ, TIMEOUT_US);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);  // start bit asserted here
  localparam logic [INH_W-1:0] INH_END  = INH_W'(INH_CYC);      // clock released here
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

`ifdef PS2_TX_CLK_FILTER_EN
  localparam bit CLK_FILT = 1'b1;
`else
  localparam bit CLK_FILT = 1'b0;
`endif

  logic clk_s, data_s, clk_prev_q, clk_fall;

  ps2_host_tx_line_sync #(.FILTER_EN(CLK_FILT), .FILTER_LEN(FILTER_LEN)) u_clk_sync (
    .CLK50MHz (CLK50MHz),
    .nRESET   (nRESET),
    .line_i   (ps2_clk_in),
    .lvl_o    (clk_s)
  );

  ps2_host_tx_line_sync #(.FILTER_EN(1'b0), .FILTER_LEN(FILTER_LEN)) u_data_sync (
    .CLK50MHz (CLK50MHz),
    .nRESET   (nRESET),
    .line_i   (ps2_data_in),
    .lvl_o    (data_s)
  );

  always_ff @(posedge CLK50MHz) begin
    if (!nRESET) clk_prev_q <= 1'b1;
    else         clk_prev_q <= clk_s;
  end

  assign clk_fall = clk_prev_q & ~clk_s;

  state_e                  state_q;
  logic [FRAME_BITS-1:0]   sh_q;     // {stop, parity, data[7:0], start}; bit 0 is on the wire
  logic [EDGE_W-1:0]       edge_q;
  logic [INH_W-1:0]        inh_q;
  logic [TO_W-1:0]         to_q;
  logic                    clk_oe_q, data_oe_q, busy_q, done_q, err_q;

  always_ff @(posedge CLK50MHz) begin
    if (!nRESET) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      edge_q    <= '0;
      inh_q     <= '0;
      to_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (host.wr_stb) begin
            sh_q    <= {1'b1, ~^host.wr_data, host.wr_data, 1'b0};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            inh_q   <= '0;
            state_q <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          clk_oe_q <= 1'b1;
          inh_q    <= inh_q + INH_W'(1);
          // Pull data low (start bit) during the final inhibit cycle, then let go of the clock.
          if (inh_q == INH_LAST) data_oe_q <= ~sh_q[0];
          if (inh_q == INH_END) begin
            clk_oe_q <= 1'b0;
            to_q     <= '0;
            edge_q   <= '0;
            state_q  <= ST_REQ;
          end
        end

        ST_REQ, ST_SHIFT, ST_ACK, ST_WAITIDLE: begin
          to_q <= to_q + TO_W'(1);
          if (to_q == TO_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (state_q == ST_WAITIDLE) begin
            if (clk_s && data_s) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else if (clk_fall) begin
            if (state_q == ST_ACK) begin
              // Device pulls data low to acknowledge.
              done_q    <= ~data_s;
              err_q     <= data_s;
              data_oe_q <= 1'b0;
              state_q   <= ST_WAITIDLE;
            end else begin
              // Falls 1..10 put data bits, parity and stop on the line.
              data_oe_q <= ~sh_q[1];
              sh_q      <= sh_q >> 1;
              edge_q    <= edge_q + EDGE_W'(1);
              state_q   <= (edge_q == STOP_EDGE_IDX) ? ST_ACK : ST_SHIFT;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign rx_inhibit  = busy_q;
  assign host.busy   = busy_q;
  assign host.done   = done_q;
  assign host.err    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  // 1 MHz model clock: 100 us inhibit = 100 cycles, 15 ms timeout = 15000 cycles.
  localparam int INH_EXP = 100;
  localparam int TMO_EXP = 15000;

  logic CLK50MHz = 1'b0;
  logic nRESET;
  always #10 CLK50MHz = ~CLK50MHz;

  logic dev_clk, dev_data;
  logic ps2_clk_oe, ps2_data_oe, rx_inhibit;
  wire  ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
  wire  ps2_data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx_if hif();

  ps2_host_tx #(
    .CLK_HZ     (1_000_000),
    .INHIBIT_US (100),
    .TIMEOUT_US (15000),
    .FILTER_LEN (4)
  ) dut (
    .CLK50MHz    (CLK50MHz),
    .nRESET      (nRESET),
    .host        (hif),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .rx_inhibit  (rx_inhibit)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    hif.wr_data = b;
    hif.wr_stb  = 1'b1;
    @(negedge CLK50MHz);
    hif.wr_stb  = 1'b0;
  endtask

  // exp_bits[n-1] = data line level while clock is low after fall n (n=1..10).
  typedef struct {
    logic [7:0] b;
    logic       ack_low;
    logic       inject;   // strobe 0x55 during inhibit and mid-shift
    logic       glitch;   // 2-cycle clock glitch before the first real edge
    logic [9:0] exp_bits;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic run_frame(input vec_t v, output logic start_bit, output logic [9:0] got);
    logic ok;
    got       = '0;
    start_bit = 1'b1;
    ok        = 1'b0;
    strobe(v.b);
    if (v.inject) begin
      repeat (3) @(negedge CLK50MHz);
      strobe(8'h55);
    end
    for (int i = 0; i < 2000; i++) begin
      if (hif.busy && !ps2_clk_oe && ps2_data_oe) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK50MHz);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_wait: actual no request-to-send required request within 2000 cycles");
      return;
    end
    start_bit = ps2_data_line;
    repeat (5) @(negedge CLK50MHz);
    if (v.glitch) begin
      dev_clk = 1'b0;
      repeat (2) @(negedge CLK50MHz);
      dev_clk = 1'b1;
      repeat (20) @(negedge CLK50MHz);
    end
    for (int n = 1; n <= 10; n++) begin
      dev_clk = 1'b0;
      repeat (10) @(negedge CLK50MHz);
      if (v.inject && n == 4) strobe(8'h55);
      repeat (10) @(negedge CLK50MHz);
      got[n-1] = ps2_data_line;
      dev_clk  = 1'b1;
      repeat (20) @(negedge CLK50MHz);
    end
    if (v.ack_low) dev_data = 1'b0;
    repeat (5) @(negedge CLK50MHz);
    dev_clk = 1'b0;
    repeat (20) @(negedge CLK50MHz);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (!hif.busy) break;
      @(negedge CLK50MHz);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       sb, saw;
    logic [9:0] got;
    int         cnt, both, k;

    // Hand-computed frames: {stop=1, odd parity, data}.
    vecs.push_back('{8'hED, 1'b1, 1'b0, 1'b0, 10'h3ED, 1'b1, 1'b0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 10'h300, 1'b1, 1'b0});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b0, 10'h201, 1'b1, 1'b0});
    vecs.push_back('{8'hED, 1'b0, 1'b0, 1'b0, 10'h3ED, 1'b0, 1'b1});
    vecs.push_back('{8'hF4, 1'b1, 1'b1, 1'b0, 10'h2F4, 1'b1, 1'b0});
`ifdef PS2_TX_CLK_FILTER_EN
    vecs.push_back('{8'h55, 1'b1, 1'b0, 1'b1, 10'h355, 1'b1, 1'b0});
`endif
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 10'h3FF, 1'b1, 1'b0});

    nRESET      = 1'b0;
    hif.wr_stb  = 1'b0;
    hif.wr_data = 8'h00;
    dev_clk     = 1'b1;
    dev_data    = 1'b1;
    repeat (3) @(negedge CLK50MHz);
    check("reset_outputs",
          32'({ps2_clk_oe, ps2_data_oe, rx_inhibit, hif.busy, hif.done, hif.err}), 32'd0);
    nRESET = 1'b1;
    repeat (5) @(negedge CLK50MHz);

    foreach (vecs[i]) begin
      run_frame(vecs[i], sb, got);
      check($sformatf("v%0d_start_bit", i), 32'(sb), 32'd0);
      check($sformatf("v%0d_bits", i), 32'(got), 32'(vecs[i].exp_bits));
      check($sformatf("v%0d_done", i), 32'(hif.done), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_err", i), 32'(hif.err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_idle", i),
            32'({hif.busy, rx_inhibit, ps2_clk_oe, ps2_data_oe}), 32'd0);
      if (vecs[i].inject) begin
        saw = 1'b0;
        repeat (300) begin
          @(negedge CLK50MHz);
          if (ps2_clk_oe || hif.busy) saw = 1'b1;
        end
        check($sformatf("v%0d_no_resend", i), 32'(saw), 32'd0);
      end
      repeat (10) @(negedge CLK50MHz);
    end

    // Load latency, inhibit length, sticky clear, then a device that never clocks.
    strobe(8'hA5);
    check("lat1_busy_done_clr",
          32'({hif.busy, rx_inhibit, ps2_clk_oe, hif.done, hif.err}), 32'b11000);
    @(negedge CLK50MHz);
    check("lat2_clk_oe", 32'(ps2_clk_oe), 32'd1);
    cnt  = 0;
    both = 0;
    for (int i = 0; i < 1000 && ps2_clk_oe; i++) begin
      cnt++;
      if (ps2_data_oe) both++;
      @(negedge CLK50MHz);
    end
    check("inhibit_len", 32'(cnt), 32'(INH_EXP));
    check("start_overlap", 32'(both), 32'd1);
    check("req_data_held", 32'(ps2_data_oe), 32'd1);
    k = 0;
    while (!hif.err && k < 20000) begin
      @(negedge CLK50MHz);
      k++;
    end
    check("timeout_cycles", 32'(k), 32'(TMO_EXP));
    check("timeout_state",
          32'({hif.err, hif.done, hif.busy, ps2_clk_oe, ps2_data_oe}), 32'b10000);

    // Strobe coincident with reset: reset wins.
    repeat (5) @(negedge CLK50MHz);
    nRESET      = 1'b0;
    hif.wr_data = 8'h12;
    hif.wr_stb  = 1'b1;
    @(negedge CLK50MHz);
    hif.wr_stb = 1'b0;
    check("stb_vs_reset",
          32'({ps2_clk_oe, ps2_data_oe, rx_inhibit, hif.busy, hif.done, hif.err}), 32'd0);
    nRESET = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge CLK50MHz);
      if (ps2_clk_oe || hif.busy) saw = 1'b1;
    end
    check("stb_vs_reset_idle", 32'(saw), 32'd0);

    // Reset in the middle of the data bits.
    strobe(8'hED);
    for (int i = 0; i < 2000; i++) begin
      if (hif.busy && !ps2_clk_oe && ps2_data_oe) break;
      @(negedge CLK50MHz);
    end
    repeat (5) @(negedge CLK50MHz);
    for (int n = 0; n < 3; n++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge CLK50MHz);
      dev_clk = 1'b1;
      repeat (20) @(negedge CLK50MHz);
    end
    dev_clk = 1'b0;
    repeat (10) @(negedge CLK50MHz);
    check("midshift_busy", 32'({hif.busy, ps2_clk_oe}), 32'b10);
    nRESET = 1'b0;
    @(negedge CLK50MHz);
    check("midshift_reset",
          32'({ps2_clk_oe, ps2_data_oe, rx_inhibit, hif.busy, hif.done, hif.err}), 32'd0);
    dev_clk = 1'b1;
    @(negedge CLK50MHz);
    nRESET = 1'b1;
    repeat (10) @(negedge CLK50MHz);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
